// File: rtl/sig_capture.sv
// ============================================================================
// Module      : sig_capture
// Description : Triggered capture of decimated {sin,cos} sample pairs into RAM,
//               streamed out over valid/ready. Optional macro
//               SIG_CAPTURE_TRIG_COUNT_EN prepends an arm-to-trigger cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_capture #(
    parameter int DEPTH = 256,
    parameter int DECIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sin_in,
    input  logic [7:0]  cos_in,
    input  logic [7:0]  trig_level,
    input  logic        arm,
    input  logic        force_trig,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(DEPTH - 1);
    localparam logic [15:0]     c_DECIM_MAX = 16'(DECIM - 1);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ARMED   = 2'd1;
    localparam logic [1:0] c_S_CAPTURE = 2'd2;
    localparam logic [1:0] c_S_READOUT = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [15:0]     r_dcnt;
    logic [7:0]      r_prev_sin;
    logic            r_prev_valid;
    logic [15:0]     r_mem [DEPTH];
    logic [15:0]     r_data;
    logic            r_valid;
    logic            r_last;
    logic            r_done;
    logic            r_rd_all;

    logic            w_level;
    logic            w_trig;
    logic            w_cap_hit;
    logic            w_we;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_load;
    logic            w_hdr_pend;
    logic [15:0]     w_hdr_word;

    // Rising crossing: previous sample strictly below, current at or above.
    assign w_level   = r_prev_valid
                     && ($signed(r_prev_sin) < $signed(trig_level))
                     && ($signed(sin_in) >= $signed(trig_level));
    assign w_trig    = (r_state == c_S_ARMED) && (w_level || force_trig);
    assign w_cap_hit = (r_state == c_S_CAPTURE) && (r_dcnt == c_DECIM_MAX);
    assign w_we      = !rst && (w_trig || w_cap_hit);
    assign w_hs      = r_valid && m_ready;
    assign w_last_hs = (r_state == c_S_READOUT) && w_hs && r_last;
    assign w_load    = (r_state == c_S_READOUT) && (!r_valid || m_ready)
                     && (w_hdr_pend || !r_rd_all);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (arm)                                  w_state_nxt = c_S_ARMED;
            c_S_ARMED:   if (w_trig)                               w_state_nxt = c_S_CAPTURE;
            c_S_CAPTURE: if (w_cap_hit && (r_wptr == c_LAST_ADDR)) w_state_nxt = c_S_READOUT;
            c_S_READOUT: if (w_last_hs)                            w_state_nxt = c_S_IDLE;
            default:                                               w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_dcnt       <= '0;
            r_prev_sin   <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (arm) begin
                        r_prev_valid <= 1'b0;
                        r_wptr       <= '0;
                    end
                end
                c_S_ARMED: begin
                    r_prev_sin   <= sin_in;
                    r_prev_valid <= 1'b1;
                    if (w_trig) begin
                        r_wptr <= c_AW'(1);
                        r_dcnt <= '0;
                    end
                end
                c_S_CAPTURE: begin
                    if (w_cap_hit) begin
                        r_dcnt <= '0;
                        r_wptr <= r_wptr + c_AW'(1);
                    end else begin
                        r_dcnt <= r_dcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The trigger-cycle sample lands at address 0 because r_wptr is 0 in ARMED.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wptr] <= {sin_in, cos_in};
    end

`ifdef SIG_CAPTURE_TRIG_COUNT_EN
    logic [15:0] r_tcnt;
    logic        r_hdr_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt     <= '0;
            r_hdr_pend <= 1'b0;
        end else begin
            if ((r_state == c_S_IDLE) && arm)
                r_tcnt <= '0;
            else if ((r_state == c_S_ARMED) && (r_tcnt != 16'hFFFF))
                r_tcnt <= r_tcnt + 16'd1;
            if (r_state == c_S_CAPTURE)
                r_hdr_pend <= 1'b1;
            else if (w_load)
                r_hdr_pend <= 1'b0;
        end
    end

    assign w_hdr_pend = r_hdr_pend;
    assign w_hdr_word = r_tcnt;
`else
    assign w_hdr_pend = 1'b0;
    assign w_hdr_word = 16'h0000;
`endif

    // Output register doubles as the prefetch stage: it reloads on the same
    // edge that retires the current word, so a held m_ready gives no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_rptr   <= '0;
            r_rd_all <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (r_state != c_S_READOUT) begin
                r_rptr   <= '0;
                r_rd_all <= 1'b0;
                r_valid  <= 1'b0;
                r_last   <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                if (w_hdr_pend) begin
                    r_data <= w_hdr_word;
                    r_last <= 1'b0;
                end else begin
                    r_data   <= r_mem[r_rptr];
                    r_last   <= (r_rptr == c_LAST_ADDR);
                    r_rd_all <= (r_rptr == c_LAST_ADDR);
                    r_rptr   <= r_rptr + c_AW'(1);
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign m_data  = r_data;
    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign busy    = (r_state != c_S_IDLE);
    assign done    = r_done;

endmodule

`default_nettype wire
